// File: rtl/cipher_ser_pkg.sv
// -----------------------------------------------------------------------------
// cipher_ser_pkg
// Shared definitions for the cipher output serializer:
//   - default word / byte / FIFO-depth sizes
//   - serializer FSM state encoding
//   - FIFO entry layout {mode, word} (mode bit is the MSB of an entry)
// No ports; imported by the serializer top and its FIFO.
// -----------------------------------------------------------------------------
package cipher_ser_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int BYTE_W_DEF = 8;
    localparam int DEPTH_DEF  = 2;

    // Serializer FSM: IDLE waits for a word, HI presents the high byte,
    // LO presents the low byte (and may chain straight into the next word).
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2
    } ser_state_e;

    // FIFO entry layout at the default word width.
    typedef struct packed {
        logic                  mode;
        logic [DATA_W_DEF-1:0] word;
    } fifo_entry_t;

    // Build an entry at the default width in the {mode, word} layout.
    function automatic fifo_entry_t make_entry(input logic mode,
                                               input logic [DATA_W_DEF-1:0] word);
        fifo_entry_t e;
        e.mode = mode;
        e.word = word;
        return e;
    endfunction

endpackage

// File: rtl/cipher_ser_if.sv
// -----------------------------------------------------------------------------
// cipher_ser_if
// Byte-wide valid/ready stream leaving the serializer.
//   out_byte  : current output byte                 (master -> slave)
//   out_valid : out_byte/out_last/out_mode valid     (master -> slave)
//   out_last  : marks the low (second) byte of a word (master -> slave)
//   out_mode  : encode/decode flag of the word        (master -> slave)
//   out_ready : sink accepts the byte                 (slave  -> master)
// -----------------------------------------------------------------------------
interface cipher_ser_if #(
    parameter int BYTE_W = 8
);
    logic [BYTE_W-1:0] out_byte;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              out_mode;

    modport master (
        output out_byte,
        output out_valid,
        output out_last,
        output out_mode,
        input  out_ready
    );

    modport slave (
        input  out_byte,
        input  out_valid,
        input  out_last,
        input  out_mode,
        output out_ready
    );
endinterface

// File: rtl/cipher_ser_fifo.sv
// -----------------------------------------------------------------------------
// ser_fifo
// Small synchronous FIFO (W bits x DEPTH entries) for the serializer.
// A push while full is still accepted when a pop happens on the same edge:
// the popped slot is the one the tail pointer lands on, so the new word
// overwrites the old head only after it has been read out.
//   clka      : clock
//   restart   : async active-low reset
//   push      : write push_data at the tail (dropped if full without pop)
//   pop       : remove head entry (ignored when empty)
//   push_data : entry to write
//   head_data : entry at the head (combinational read)
//   count     : number of stored entries (saturating)
//   full      : registered, count == DEPTH
//   empty     : count == 0
// -----------------------------------------------------------------------------
module ser_fifo
    import cipher_ser_pkg::*;
#(
    parameter int W     = DATA_W_DEF + 1,
    parameter int DEPTH = DEPTH_DEF,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clka,
    input  logic             restart,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     push_data,
    output logic [W-1:0]     head_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nx_s;
    logic             full_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Pointer advance that wraps modulo DEPTH (DEPTH need not be a power of 2).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_LAST) begin
            r = '0;
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    assign empty     = (count_r == CNT_W'(0));
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & ((count_r != CNT_MAX) | pop_ok_s);
    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign full      = full_r;

    // Saturating next-state count: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_nx_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10: begin
                if (count_r != CNT_MAX) begin
                    count_nx_s = count_r + CNT_W'(1);
                end else begin
                    count_nx_s = count_r;
                end
            end
            2'b01: begin
                if (count_r != CNT_W'(0)) begin
                    count_nx_s = count_r - CNT_W'(1);
                end else begin
                    count_nx_s = count_r;
                end
            end
            default: count_nx_s = count_r;
        endcase
    end

    // Storage, pointers, count and registered full flag.
    always_ff @(posedge clka or negedge restart) begin
        if (!restart) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r <= count_nx_s;
            full_r  <= (count_nx_s == CNT_MAX);
        end
    end

endmodule

// File: rtl/cipher_ser.sv
// -----------------------------------------------------------------------------
// cipher_ser
// Output serializer behind the cipher datapath. Captures a finished result
// word on a one-cycle strobe, queues up to DEPTH words, and sends each word
// as two bytes (high byte first) on a valid/ready byte stream.
//   clka      : clock, rising edge
//   restart   : async active-low reset
//   cap_en    : capture strobe, data_in holds a finished result
//   cap_mode  : encode(1)/decode(0) flag sampled with cap_en
//   data_in   : result word
//   bus       : byte stream (out_byte/out_valid/out_last/out_mode, out_ready)
//   fifo_full : registered, FIFO holds DEPTH words
//   overflow  : sticky, a capture was dropped (cleared only by reset)
// -----------------------------------------------------------------------------
module cipher_ser
    import cipher_ser_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int BYTE_W = BYTE_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int ENT_W = DATA_W + 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clka,
    input  logic              restart,
    input  logic              cap_en,
    input  logic              cap_mode,
    input  logic [DATA_W-1:0] data_in,
    cipher_ser_if.master      bus,
    output logic              fifo_full,
    output logic              overflow
);

    ser_state_e        state_r;
    ser_state_e        state_nx_s;

    logic [ENT_W-1:0]  push_data_s;
    logic [ENT_W-1:0]  head_data_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              pop_s;
    logic              hs_s;
    logic              drop_s;

    logic [BYTE_W-1:0] out_byte_r;
    logic              out_valid_r;
    logic              out_last_r;
    logic              out_mode_r;
    logic [BYTE_W-1:0] lo_byte_r;
    logic              overflow_r;

    logic [BYTE_W-1:0] out_byte_nx_s;
    logic              out_valid_nx_s;
    logic              out_last_nx_s;
    logic              out_mode_nx_s;
    logic [BYTE_W-1:0] lo_byte_nx_s;

    // Entry layout {mode, word}: mode rides along in the MSB.
    assign push_data_s = {cap_mode, data_in};
    assign hs_s        = out_valid_r & bus.out_ready;
    // A capture is lost only when the FIFO is full and nothing leaves this edge.
    assign drop_s      = cap_en & (fifo_count_s == CNT_W'(DEPTH)) & ~pop_s;

    ser_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clka      (clka),
        .restart   (restart),
        .push      (cap_en),
        .pop       (pop_s),
        .push_data (push_data_s),
        .head_data (head_data_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // FSM state register.
    always_ff @(posedge clka or negedge restart) begin
        if (!restart) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic; LO chains straight into HI when a word is waiting.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    state_nx_s = ST_HI;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_HI: begin
                if (hs_s) begin
                    state_nx_s = ST_LO;
                end else begin
                    state_nx_s = ST_HI;
                end
            end
            ST_LO: begin
                if (hs_s && !fifo_empty_s) begin
                    state_nx_s = ST_HI;
                end else if (hs_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_LO;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM output logic: pop request and next values of the output registers.
    // Without a handshake everything holds, which keeps the stream stable
    // under backpressure.
    always_comb begin
        pop_s          = 1'b0;
        out_byte_nx_s  = out_byte_r;
        out_valid_nx_s = out_valid_r;
        out_last_nx_s  = out_last_r;
        out_mode_nx_s  = out_mode_r;
        lo_byte_nx_s   = lo_byte_r;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s          = 1'b1;
                    out_byte_nx_s  = head_data_s[DATA_W-1 -: BYTE_W];
                    lo_byte_nx_s   = head_data_s[BYTE_W-1:0];
                    out_mode_nx_s  = head_data_s[DATA_W];
                    out_valid_nx_s = 1'b1;
                    out_last_nx_s  = 1'b0;
                end else begin
                    out_valid_nx_s = 1'b0;
                    out_last_nx_s  = 1'b0;
                end
            end
            ST_HI: begin
                if (hs_s) begin
                    out_byte_nx_s = lo_byte_r;
                    out_last_nx_s = 1'b1;
                end else begin
                    out_last_nx_s = out_last_r;
                end
            end
            ST_LO: begin
                if (hs_s && !fifo_empty_s) begin
                    pop_s          = 1'b1;
                    out_byte_nx_s  = head_data_s[DATA_W-1 -: BYTE_W];
                    lo_byte_nx_s   = head_data_s[BYTE_W-1:0];
                    out_mode_nx_s  = head_data_s[DATA_W];
                    out_valid_nx_s = 1'b1;
                    out_last_nx_s  = 1'b0;
                end else if (hs_s) begin
                    out_valid_nx_s = 1'b0;
                    out_last_nx_s  = 1'b0;
                end else begin
                    out_valid_nx_s = out_valid_r;
                end
            end
            default: begin
                out_valid_nx_s = 1'b0;
                out_last_nx_s  = 1'b0;
            end
        endcase
    end

    // Output, low-byte holding and sticky overflow registers.
    always_ff @(posedge clka or negedge restart) begin
        if (!restart) begin
            out_byte_r  <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_mode_r  <= 1'b0;
            lo_byte_r   <= '0;
            overflow_r  <= 1'b0;
        end else begin
            out_byte_r  <= out_byte_nx_s;
            out_valid_r <= out_valid_nx_s;
            out_last_r  <= out_last_nx_s;
            out_mode_r  <= out_mode_nx_s;
            lo_byte_r   <= lo_byte_nx_s;
            overflow_r  <= overflow_r | drop_s;
        end
    end

    assign bus.out_byte  = out_byte_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_last  = out_last_r;
    assign bus.out_mode  = out_mode_r;
    assign fifo_full     = fifo_full_s;
    assign overflow      = overflow_r;

endmodule
